// File: rtl/i2cmb_seq_pkg.sv
// i2cmb_seq_pkg: shared register map, command/status codes and sequencer states
package i2cmb_seq_pkg;

   localparam logic [1:0] ADR_CSR    = 2'd0;
   localparam logic [1:0] ADR_DPR    = 2'd1;
   localparam logic [1:0] ADR_CMDR   = 2'd2;
   localparam logic [7:0] CSR_ENABLE = 8'hC0;

   typedef enum logic [2:0] {
      OP_WAIT     = 3'b000,
      OP_WRITE    = 3'b001,
      OP_READ_ACK = 3'b010,
      OP_READ_NAK = 3'b011,
      OP_START    = 3'b100,
      OP_STOP     = 3'b101,
      OP_SET_BUS  = 3'b110
   } op_e;

   typedef enum logic [2:0] {
      RSP_NONE    = 3'd0,
      RSP_DONE    = 3'd1,
      RSP_NAK     = 3'd2,
      RSP_AL      = 3'd3,
      RSP_ERR     = 3'd4,
      RSP_TIMEOUT = 3'd5
   } status_e;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_WR_DPR, S_WR_CMDR, S_WAIT_IRQ, S_RD_CMDR, S_RD_DPR, S_RESP
   } state_e;

   // flags = CMDR[7:4] = {DON, NAK, AL, ERR}; no flag at all is treated as an error
   function automatic status_e flags_to_status(input logic [3:0] flags);
      return flags[0] ? RSP_ERR : flags[1] ? RSP_AL : flags[2] ? RSP_NAK :
             flags[3] ? RSP_DONE : RSP_ERR;
   endfunction

   function automatic logic uses_dpr(input op_e op);
      return op inside {OP_WRITE, OP_SET_BUS, OP_WAIT};
   endfunction

   function automatic logic is_read(input op_e op);
      return op inside {OP_READ_ACK, OP_READ_NAK};
   endfunction

endpackage

// File: rtl/i2cmb_wb_master_port.sv
// i2cmb_wb_master_port: single Wishbone read/write cycle with start/done handshake
module i2cmb_wb_master_port (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       we_i,
   input  logic [1:0] adr_i,
   input  logic [7:0] wdata_i,
   output logic       done_o,
   output logic [7:0] rdata_o,
   output logic       cyc_o,
   output logic       stb_o,
   output logic       we_o,
   output logic [1:0] adr_o,
   output logic [7:0] dat_o,
   input  logic [7:0] dat_i,
   input  logic       ack_i
);

   logic       cyc_q, cyc_d, we_q, we_d;
   logic [1:0] adr_q, adr_d;
   logic [7:0] dat_q, dat_d;

   assign done_o  = cyc_q && ack_i;
   assign rdata_o = dat_i;
   assign cyc_o   = cyc_q;
   assign stb_o   = cyc_q;
   assign we_o    = we_q;
   assign adr_o   = adr_q;
   assign dat_o   = dat_q;

   // launch only from idle, so the cycle after an ack is always a bus-idle cycle
   always_comb begin
      cyc_d = cyc_q;
      we_d  = we_q;
      adr_d = adr_q;
      dat_d = dat_q;
      if (cyc_q && ack_i) begin
         cyc_d = 1'b0;
         we_d  = 1'b0;
         adr_d = '0;
         dat_d = '0;
      end else if (!cyc_q && start_i) begin
         cyc_d = 1'b1;
         we_d  = we_i;
         adr_d = adr_i;
         dat_d = wdata_i;
      end
   end

   // bus signal registers, dropped at once by reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         adr_q <= '0;
         dat_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         we_q  <= we_d;
         adr_q <= adr_d;
         dat_q <= dat_d;
      end
   end

endmodule

// File: rtl/i2cmb_cmd_sequencer.sv
// i2cmb_cmd_sequencer: turns I2C commands into I2CMB register sequences (I2CMB_SEQ_TIMEOUT_EN adds irq watchdog)
module i2cmb_cmd_sequencer
   import i2cmb_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic [2:0] req_op_i,
   input  logic [7:0] req_data_i,
   output logic       rsp_valid_o,
   output logic [2:0] rsp_status_o,
   output logic [7:0] rsp_data_o,
   output logic       cyc_o,
   output logic       stb_o,
   output logic       we_o,
   output logic [1:0] adr_o,
   output logic [7:0] dat_o,
   input  logic [7:0] dat_i,
   input  logic       ack_i,
   input  logic       irq_i
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e     state_q, state_d;
   op_e        op_q, op_d;
   status_e    status_q, status_d;
   logic [7:0] data_q, data_d, rdata_q, rdata_d, bus_rdata, bus_wdata;
   logic [1:0] bus_adr;
   logic       bus_start, bus_we, bus_done, tmo_hit;

   assign req_ready_o  = state_q == S_IDLE;
   assign rsp_valid_o  = state_q == S_RESP;
   assign rsp_status_o = status_q;
   assign rsp_data_o   = rdata_q;

   assign bus_start = (state_q inside {S_INIT, S_WR_DPR, S_WR_CMDR, S_RD_CMDR, S_RD_DPR}) && !cyc_o;
   assign bus_we    = !(state_q inside {S_RD_CMDR, S_RD_DPR});
   assign bus_adr   = (state_q inside {S_WR_CMDR, S_RD_CMDR}) ? ADR_CMDR :
                      (state_q inside {S_WR_DPR, S_RD_DPR})   ? ADR_DPR  : ADR_CSR;
   assign bus_wdata = (state_q == S_INIT)    ? CSR_ENABLE :
                      (state_q == S_WR_DPR)  ? data_q     :
                      (state_q == S_WR_CMDR) ? {5'b0, op_q} : 8'h00;

   i2cmb_wb_master_port u_wb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (bus_start),
      .we_i    (bus_we),
      .adr_i   (bus_adr),
      .wdata_i (bus_wdata),
      .done_o  (bus_done),
      .rdata_o (bus_rdata),
      .cyc_o   (cyc_o),
      .stb_o   (stb_o),
      .we_o    (we_o),
      .adr_o   (adr_o),
      .dat_o   (dat_o),
      .dat_i   (dat_i),
      .ack_i   (ack_i)
   );

`ifdef I2CMB_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_d   = (state_q == S_WAIT_IRQ) ? tmo_q + TW'(1) : '0;
   assign tmo_hit = (state_q == S_WAIT_IRQ) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // counts cycles spent in WAIT_IRQ, cleared whenever outside it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // next-state and response capture; status and data settle on entry to RESP
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      case (state_q)
         S_INIT:     if (bus_done) state_d = S_IDLE;
         S_IDLE:
            if (req_valid_i) begin
               op_d    = op_e'(req_op_i);
               data_d  = req_data_i;
               state_d = uses_dpr(op_e'(req_op_i)) ? S_WR_DPR : S_WR_CMDR;
            end
         S_WR_DPR:   if (bus_done) state_d = S_WR_CMDR;
         S_WR_CMDR:  if (bus_done) state_d = S_WAIT_IRQ;
         S_WAIT_IRQ:
            if (irq_i) state_d = S_RD_CMDR;
            else if (tmo_hit) begin
               status_d = RSP_TIMEOUT;
               rdata_d  = '0;
               state_d  = S_RESP;
            end
         S_RD_CMDR:
            if (bus_done) begin
               status_d = flags_to_status(bus_rdata[7:4]);
               if (is_read(op_q) && bus_rdata[7]) state_d = S_RD_DPR;
               else begin
                  rdata_d = '0;
                  state_d = S_RESP;
               end
            end
         S_RD_DPR:
            if (bus_done) begin
               rdata_d = bus_rdata;
               state_d = S_RESP;
            end
         S_RESP:     state_d = S_IDLE;
      endcase
   end

   // sequencer state and captured command/response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_INIT;
         op_q     <= OP_WAIT;
         data_q   <= '0;
         status_q <= RSP_NONE;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// tb_i2cmb_cmd_sequencer: directed self-checking bench with a Wishbone slave/irq model
module tb_i2cmb_cmd_sequencer;

   localparam logic [2:0] OP_WAIT = 3'b000, OP_WRITE = 3'b001, OP_RACK = 3'b010, OP_RNAK = 3'b011;
   localparam logic [2:0] OP_START = 3'b100, OP_STOP = 3'b101, OP_SETBUS = 3'b110;

   logic       clk_i = 1'b0, rst_i = 1'b1;
   logic       req_valid_i = 1'b0, req_ready_o;
   logic [2:0] req_op_i = '0;
   logic [7:0] req_data_i = '0;
   logic       rsp_valid_o;
   logic [2:0] rsp_status_o;
   logic [7:0] rsp_data_o;
   logic       cyc_o, stb_o, we_o, ack_i = 1'b0, irq_i = 1'b0;
   logic [1:0] adr_o;
   logic [7:0] dat_o, dat_i;
   logic [7:0] cmdr_val = 8'h80, dpr_val = 8'h00;

   int checks = 0, errors = 0;

   i2cmb_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
   );

   always #5 clk_i = ~clk_i;

   assign dat_i = (adr_o == 2'd2) ? cmdr_val : (adr_o == 2'd1) ? dpr_val : 8'h00;

   // Wishbone slave model: acks after ack_delay idle negedges, logs each accepted cycle
   logic [10:0] bus_q[$], rsp_q[$];
   logic [10:0] cap;
   bit          in_cyc = 0;
   int          wcnt = 0, ack_delay = 0, stable_viol = 0;

   always @(negedge clk_i) begin
      if (cyc_o) begin
         if (!in_cyc) begin
            in_cyc = 1;
            cap = {we_o, adr_o, dat_o};
            wcnt = 0;
         end else if ({we_o, adr_o, dat_o} !== cap || !stb_o) stable_viol++;
         if (wcnt == ack_delay) begin
            ack_i = 1'b1;
            bus_q.push_back(cap);
         end else begin
            ack_i = 1'b0;
            wcnt++;
         end
      end else begin
         ack_i = 1'b0;
         in_cyc = 0;
      end
      if (rsp_valid_o) rsp_q.push_back({rsp_status_o, rsp_data_o});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got hang want finish");
      $fatal(1);
   end

   function automatic logic [10:0] br(input logic w, input logic [1:0] a, input logic [7:0] d);
      return {w, a, d};
   endfunction

   function automatic logic [10:0] bq(input int i);
      return (i < bus_q.size()) ? bus_q[i] : 11'hx;
   endfunction

   function automatic logic [10:0] rq(input int i);
      return (i < rsp_q.size()) ? rsp_q[i] : 11'hx;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_i);
         #1;
      end
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (!req_ready_o && n < 100) begin
         tick(1);
         n++;
      end
      ok = req_ready_o;
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] data, output bit ok);
      wait_ready(ok);
      req_op_i = op;
      req_data_i = data;
      req_valid_i = ok;
      tick(1);
      req_valid_i = 1'b0;
   endtask

   task automatic wait_bus(input int cnt, output bit ok);
      int n = 0;
      while (bus_q.size() < cnt && n < 100) begin
         tick(1);
         n++;
      end
      ok = bus_q.size() >= cnt;
   endtask

   task automatic wait_rsp(output bit ok);
      int n = 0;
      while (rsp_q.size() == 0 && n < 200) begin
         tick(1);
         n++;
      end
      ok = rsp_q.size() != 0;
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input int npre,
                          input int irqd, output bit ok);
      bit a, b, c;
      bus_q.delete();
      rsp_q.delete();
      send(op, data, a);
      wait_bus(npre, b);
      tick(irqd);
      irq_i = 1'b1;
      tick(1);
      irq_i = 1'b0;
      wait_rsp(c);
      tick(2);
      ok = a && b && c;
   endtask

   task automatic test_reset;
      bit ok;
      rst_i = 1'b1;
      tick(2);
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready_o); end
      checks++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin errors++; $display("FAIL reset_bus_ctl: got %b want 000", {cyc_o, stb_o, we_o}); end
      checks++; if ({adr_o, dat_o} !== 10'h0) begin errors++; $display("FAIL reset_bus_data: got %h want 000", {adr_o, dat_o}); end
      checks++; if ({rsp_valid_o, rsp_status_o, rsp_data_o} !== 12'h0) begin errors++; $display("FAIL reset_rsp: got %h want 000", {rsp_valid_o, rsp_status_o, rsp_data_o}); end
      bus_q.delete();
      rsp_q.delete();
      rst_i = 1'b0;
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL reset_ready_rise: got 0 want 1 within 100 cycles"); end
      checks++; if (bus_q.size() !== 1 || bq(0) !== br(1, 2'd0, 8'hC0)) begin errors++; $display("FAIL reset_csr_write: got %0d cycles first %h want 1 cycle %h", bus_q.size(), bq(0), br(1, 2'd0, 8'hC0)); end
   endtask

   task automatic test_write;
      bit ok;
      cmdr_val = 8'h80;
      run_cmd(OP_WRITE, 8'hA5, 2, 10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL write_progress: got stall want response"); end
      checks++; if (bus_q.size() !== 3) begin errors++; $display("FAIL write_bus_count: got %0d want 3", bus_q.size()); end
      checks++; if (bq(0) !== br(1, 2'd1, 8'hA5)) begin errors++; $display("FAIL write_dpr: got %h want %h", bq(0), br(1, 2'd1, 8'hA5)); end
      checks++; if (bq(1) !== br(1, 2'd2, 8'h01)) begin errors++; $display("FAIL write_cmdr: got %h want %h", bq(1), br(1, 2'd2, 8'h01)); end
      checks++; if (bq(2) !== br(0, 2'd2, 8'h00)) begin errors++; $display("FAIL write_rd_cmdr: got %h want %h", bq(2), br(0, 2'd2, 8'h00)); end
      checks++; if (rsp_q.size() !== 1 || rq(0) !== {3'd1, 8'h00}) begin errors++; $display("FAIL write_rsp: got %0d rsp first %h want 1 rsp %h", rsp_q.size(), rq(0), {3'd1, 8'h00}); end
   endtask

   task automatic test_read_nak;
      bit ok;
      cmdr_val = 8'h80;
      dpr_val = 8'h3C;
      run_cmd(OP_RNAK, 8'h00, 1, 1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnak_progress: got stall want response"); end
      checks++; if (bus_q.size() !== 3) begin errors++; $display("FAIL rnak_bus_count: got %0d want 3", bus_q.size()); end
      checks++; if (bq(0) !== br(1, 2'd2, 8'h03)) begin errors++; $display("FAIL rnak_cmdr: got %h want %h", bq(0), br(1, 2'd2, 8'h03)); end
      checks++; if (bq(2) !== br(0, 2'd1, 8'h00)) begin errors++; $display("FAIL rnak_rd_dpr: got %h want %h", bq(2), br(0, 2'd1, 8'h00)); end
      checks++; if (rsp_q.size() !== 1 || rq(0) !== {3'd1, 8'h3C}) begin errors++; $display("FAIL rnak_rsp: got %0d rsp first %h want 1 rsp %h", rsp_q.size(), rq(0), {3'd1, 8'h3C}); end
      tick(3);
      checks++; if ({rsp_valid_o, rsp_data_o} !== {1'b0, 8'h3C}) begin errors++; $display("FAIL rnak_data_hold: got %h want %h", {rsp_valid_o, rsp_data_o}, {1'b0, 8'h3C}); end
   endtask

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] data;
      logic [7:0] cmdr;
      logic [3:0] npre;
      logic [3:0] nbus;
      logic [2:0] st;
      logic [7:0] rd;
   } vec_t;

   task automatic test_status;
      vec_t v[8];
      bit ok;
      v = '{'{OP_START,  8'h00, 8'hA0, 4'd1, 4'd2, 3'd3, 8'h00},
            '{OP_START,  8'h00, 8'hC0, 4'd1, 4'd2, 3'd2, 8'h00},
            '{OP_STOP,   8'h00, 8'h90, 4'd1, 4'd2, 3'd4, 8'h00},
            '{OP_RACK,   8'h00, 8'h00, 4'd1, 4'd2, 3'd4, 8'h00},
            '{OP_RACK,   8'h00, 8'h80, 4'd1, 4'd3, 3'd1, 8'h5A},
            '{OP_RACK,   8'h00, 8'h90, 4'd1, 4'd3, 3'd4, 8'h5A},
            '{OP_SETBUS, 8'h05, 8'h80, 4'd2, 4'd3, 3'd1, 8'h00},
            '{OP_WAIT,   8'h0A, 8'h80, 4'd2, 4'd3, 3'd1, 8'h00}};
      dpr_val = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         cmdr_val = v[i].cmdr;
         run_cmd(v[i].op, v[i].data, int'(v[i].npre), 1, ok);
         checks++; if (!ok) begin errors++; $display("FAIL status_progress[%0d]: got stall want response", i); end
         checks++; if (bus_q.size() !== int'(v[i].nbus)) begin errors++; $display("FAIL status_bus_count[%0d]: got %0d want %0d", i, bus_q.size(), v[i].nbus); end
         checks++; if (bq(int'(v[i].npre) - 1) !== br(1, 2'd2, {5'b0, v[i].op})) begin errors++; $display("FAIL status_cmdr[%0d]: got %h want %h", i, bq(int'(v[i].npre) - 1), br(1, 2'd2, {5'b0, v[i].op})); end
         if (v[i].npre == 4'd2) begin
            checks++; if (bq(0) !== br(1, 2'd1, v[i].data)) begin errors++; $display("FAIL status_dpr[%0d]: got %h want %h", i, bq(0), br(1, 2'd1, v[i].data)); end
         end
         checks++; if (rsp_q.size() !== 1 || rq(0) !== {v[i].st, v[i].rd}) begin errors++; $display("FAIL status_rsp[%0d]: got %0d rsp first %h want 1 rsp %h", i, rsp_q.size(), rq(0), {v[i].st, v[i].rd}); end
      end
   endtask

   task automatic test_irq_ignored;
      bit a, b, c;
      cmdr_val = 8'h80;
      irq_i = 1'b1;
      tick(3);
      irq_i = 1'b0;
      bus_q.delete();
      rsp_q.delete();
      send(OP_START, 8'h00, a);
      wait_bus(1, b);
      tick(12);
      checks++; if (!(a && b)) begin errors++; $display("FAIL irq_ign_progress: got stall want cmdr write"); end
      checks++; if (rsp_q.size() !== 0 || bus_q.size() !== 1) begin errors++; $display("FAIL irq_ign_wait: got %0d rsp %0d cycles want 0 rsp 1 cycle", rsp_q.size(), bus_q.size()); end
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL irq_ign_ready: got %b want 0", req_ready_o); end
      irq_i = 1'b1;
      tick(1);
      irq_i = 1'b0;
      wait_rsp(c);
      checks++; if (!c || rq(0) !== {3'd1, 8'h00}) begin errors++; $display("FAIL irq_ign_rsp: got %h want %h", rq(0), {3'd1, 8'h00}); end
   endtask

   task automatic measure(input logic [2:0] op, output int n);
      bit ok;
      wait_ready(ok);
      req_op_i = op;
      req_data_i = 8'h11;
      req_valid_i = ok;
      n = 0;
      do begin
         tick(1);
         n++;
         req_valid_i = 1'b0;
      end while (!rsp_valid_o && n < 50);
   endtask

   task automatic test_latency;
      int ls, lw;
      cmdr_val = 8'h80;
      irq_i = 1'b1;
      rsp_q.delete();
      measure(OP_START, ls);
      measure(OP_WRITE, lw);
      tick(3);
      irq_i = 1'b0;
      checks++; if (ls !== 6) begin errors++; $display("FAIL lat_start: got %0d want 6", ls); end
      checks++; if (lw !== 8) begin errors++; $display("FAIL lat_write: got %0d want 8", lw); end
      checks++; if (rsp_q.size() !== 2) begin errors++; $display("FAIL lat_rsp_count: got %0d want 2", rsp_q.size()); end
   endtask

   task automatic test_reset_mid;
      bit a, b;
      int n = 0;
      ack_delay = 3;
      stable_viol = 0;
      cmdr_val = 8'h80;
      bus_q.delete();
      rsp_q.delete();
      send(OP_START, 8'h00, a);
      wait_bus(1, b);
      tick(3);
      checks++; if (!(a && b) || bq(0) !== br(1, 2'd2, 8'h04)) begin errors++; $display("FAIL rmid_cmdr: got %h want %h", bq(0), br(1, 2'd2, 8'h04)); end
      checks++; if (stable_viol !== 0) begin errors++; $display("FAIL rmid_stable: got %0d changes want 0", stable_viol); end
      rst_i = 1'b1;
      tick(2);
      bus_q.delete();
      rsp_q.delete();
      rst_i = 1'b0;
      wait_ready(a);
      checks++; if (!a || bus_q.size() !== 1 || bq(0) !== br(1, 2'd0, 8'hC0)) begin errors++; $display("FAIL rmid_csr_rerun: got %0d cycles first %h want 1 cycle %h", bus_q.size(), bq(0), br(1, 2'd0, 8'hC0)); end
      tick(20);
      checks++; if (rsp_q.size() !== 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d want 0", rsp_q.size()); end
      rst_i = 1'b1;
      tick(2);
      bus_q.delete();
      rst_i = 1'b0;
      while (!cyc_o && n < 20) begin
         tick(1);
         n++;
      end
      checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL rmid_cyc_start: got %b want 1", cyc_o); end
      rst_i = 1'b1;
      #1;
      checks++; if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== 13'h0) begin errors++; $display("FAIL rmid_async_drop: got %h want 0000", {cyc_o, stb_o, we_o, adr_o, dat_o}); end
      tick(2);
      rst_i = 1'b0;
      wait_ready(a);
      checks++; if (!a || bus_q.size() !== 1 || bq(0) !== br(1, 2'd0, 8'hC0)) begin errors++; $display("FAIL rmid_csr_after_drop: got %0d cycles first %h want 1 cycle %h", bus_q.size(), bq(0), br(1, 2'd0, 8'hC0)); end
      checks++; if (stable_viol !== 0) begin errors++; $display("FAIL rmid_stable_end: got %0d changes want 0", stable_viol); end
      ack_delay = 0;
   endtask

`ifdef I2CMB_SEQ_TIMEOUT_EN
   task automatic test_timeout;
      bit a, b;
      int n = 0;
      irq_i = 1'b0;
      bus_q.delete();
      rsp_q.delete();
      send(OP_START, 8'h00, a);
      wait_bus(1, b);
      do begin
         tick(1);
         n++;
      end while (!rsp_valid_o && n < 100);
      checks++; if (n !== 17) begin errors++; $display("FAIL tmo_latency: got %0d want 17", n); end
      checks++; if ({rsp_status_o, rsp_data_o} !== {3'd5, 8'h00}) begin errors++; $display("FAIL tmo_status: got %h want %h", {rsp_status_o, rsp_data_o}, {3'd5, 8'h00}); end
      tick(1);
      checks++; if (!(a && b) || bus_q.size() !== 1 || req_ready_o !== 1'b1) begin errors++; $display("FAIL tmo_idle: got %0d cycles ready %b want 1 cycle ready 1", bus_q.size(), req_ready_o); end
   endtask
`endif

   initial begin
      test_reset;
      test_write;
      test_read_nak;
      test_status;
      test_irq_ignored;
      test_latency;
      test_reset_mid;
`ifdef I2CMB_SEQ_TIMEOUT_EN
      test_timeout;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
